// File: rtl/rv32i_gcd_job_ctrl.sv
// GCD job sequencer for the RV32I core: accepts an operand pair, runs the core
// program with the operands pinned on x28/x29, snoops the x10 result, and responds.
module rv32i_gcd_job_ctrl #(
    parameter int unsigned TIMEOUT_CYC  = 65535,
    parameter int unsigned RST_HOLD_CYC = 4,
    parameter logic [4:0]  RESULT_REG   = 5'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic        resp_timeout_o,
    output logic        core_rst_n_o,
    output logic [31:0] gcd_a_o,
    output logic [31:0] gcd_b_o,
    output logic        calc_start_o,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    output logic        busy_o
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > RST_HOLD_CYC) ? TIMEOUT_CYC : RST_HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      gcd_a_q, gcd_a_d;
    logic [31:0]      gcd_b_q, gcd_b_d;
    logic [31:0]      result_q, result_d;
    logic             timeout_q, timeout_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;

    logic accept, zero_op, result_hit, wd_expire;

    assign accept     = req_valid_i && req_ready_q;
    assign zero_op    = (req_a_i == 32'd0) || (req_b_i == 32'd0);
    assign result_hit = rd_we_i && (rd_addr_i == RESULT_REG);
    assign wd_expire  = (cnt_q == WD_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = zero_op ? RESP : LOAD;
            LOAD: if (cnt_q == HOLD_LAST) state_d = RUN;
            RUN:  if (result_hit || wd_expire) state_d = RESP;
            RESP: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the result write beats the watchdog
    always_comb begin
        cnt_d        = '0;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        run_d        = (state_d == RUN);
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gcd_a_d = req_a_i;
                    gcd_b_d = req_b_i;
                    if (zero_op) begin
                        result_d  = req_a_i | req_b_i;
                        timeout_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (cnt_q != HOLD_LAST) cnt_d = cnt_q + CNT_W'(1);
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (result_hit) begin
                    result_d  = rd_data_i;
                    timeout_d = 1'b0;
                end else if (wd_expire) begin
                    result_d  = 32'd0;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            gcd_a_q      <= 32'd0;
            gcd_b_q      <= 32'd0;
            result_q     <= 32'd0;
            timeout_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            run_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            run_q        <= run_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_result_o  = result_q;
    assign resp_timeout_o = timeout_q;
    assign core_rst_n_o   = run_q;
    assign calc_start_o   = run_q;
    assign gcd_a_o        = gcd_a_q;
    assign gcd_b_o        = gcd_b_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_rv32i_gcd_job_ctrl.sv
// Self-checking bench for rv32i_gcd_job_ctrl: per-cycle comparison against a
// job-level model plus directed scenarios with hand-computed expectations.
module tb_rv32i_gcd_job_ctrl;

    localparam int unsigned TO_CYC   = 16;
    localparam int unsigned HOLD_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_timeout;
    logic        core_rst_n;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic        calc_start;
    logic        rd_we = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] rd_data = 32'd0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    rv32i_gcd_job_ctrl #(
        .TIMEOUT_CYC (TO_CYC),
        .RST_HOLD_CYC(HOLD_CYC),
        .RESULT_REG  (5'd10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .resp_timeout_o(resp_timeout),
        .core_rst_n_o  (core_rst_n),
        .gcd_a_o       (gcd_a),
        .gcd_b_o       (gcd_b),
        .calc_start_o  (calc_start),
        .rd_we_i       (rd_we),
        .rd_addr_i     (rd_addr),
        .rd_data_i     (rd_data),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Job-level model: phase 0 idle, 1 core held in reset, 2 core running, 3 response pending
    int          m_ph;
    int          m_k;
    logic [31:0] m_a, m_b, m_res;
    logic        m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_k <= 0; m_a <= 0; m_b <= 0; m_res <= 0; m_to <= 0;
        end else begin
            case (m_ph)
                0: if (req_valid) begin
                    m_a <= req_a;
                    m_b <= req_b;
                    if (req_a == 0 || req_b == 0) begin
                        m_res <= req_a | req_b; m_to <= 0; m_ph <= 3;
                    end else begin
                        m_ph <= 1; m_k <= 0;
                    end
                end
                1: begin
                    // m_k cycles already spent in reset hold, this is one more
                    if (m_k + 1 == int'(HOLD_CYC)) begin m_ph <= 2; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
                2: begin
                    if (rd_we && rd_addr == 5'd10) begin
                        m_res <= rd_data; m_to <= 0; m_ph <= 3;
                    end else if (m_k + 1 == int'(TO_CYC)) begin
                        m_res <= 0; m_to <= 1; m_ph <= 3;
                    end else m_k <= m_k + 1;
                end
                default: if (resp_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        #1;
        chk("req_ready",   32'(req_ready),    32'(m_ph == 0));
        chk("resp_valid",  32'(resp_valid),   32'(m_ph == 3));
        chk("calc_start",  32'(calc_start),   32'(m_ph == 2));
        chk("core_rst_n",  32'(core_rst_n),   32'(m_ph == 2));
        chk("busy",        32'(busy),         32'(m_ph != 0));
        chk("gcd_a",       gcd_a,             m_a);
        chk("gcd_b",       gcd_b,             m_b);
        chk("resp_result", resp_result,       m_res);
        chk("resp_timeout",32'(resp_timeout), 32'(m_to));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic submit(input logic [31:0] a, input logic [31:0] b, output int acc);
        int n = 0;
        req_valid = 1'b1; req_a = a; req_b = b;
        while (!req_ready && n < 100) begin tick(); n++; end
        acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_calc_start();
        int n = 0;
        while (!calc_start && n < 40) begin tick(); n++; end
        chk("calc_start_seen", 32'(calc_start), 32'd1);
    endtask

    task automatic core_write(input logic [4:0] addr, input logic [31:0] data);
        rd_we = 1'b1; rd_addr = addr; rd_data = data;
        tick();
        rd_we = 1'b0; rd_addr = 5'd0; rd_data = 32'd0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    endtask

    // Submit, let the core write x10 on run cycle wcyc, check and retire the response
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int wcyc,
                           input logic [31:0] res);
        int acc;
        submit(a, b, acc);
        wait_calc_start();
        repeat (wcyc - 1) tick();
        core_write(5'd10, res);
        chk("job_resp_valid", 32'(resp_valid), 32'd1);
        chk("job_result", resp_result, res);
        handshake();
    endtask

    initial begin
        int acc;
        int run;

        repeat (3) tick();
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        rst_n = 1'b1;
        tick();

        // Normal job 48,18 -> 6 written on run cycle 10
        submit(32'd48, 32'd18, acc);
        chk("gcd_a_latched", gcd_a, 32'd48);
        wait_calc_start();
        chk("calc_start_latency", 32'(cyc - acc), 32'd5);
        repeat (9) tick();
        core_write(5'd10, 32'd6);
        chk("normal_resp_valid", 32'(resp_valid), 32'd1);
        chk("normal_result", resp_result, 32'd6);
        chk("normal_timeout", 32'(resp_timeout), 32'd0);
        chk("normal_gcd_b", gcd_b, 32'd18);
        handshake();

        // Zero-operand bypass
        submit(32'd0, 32'd35, acc);
        chk("bypass_latency", 32'(cyc - acc), 32'd1);
        chk("bypass_resp_valid", 32'(resp_valid), 32'd1);
        chk("bypass_result", resp_result, 32'd35);
        chk("bypass_core_rst_n", 32'(core_rst_n), 32'd0);
        handshake();

        // Watchdog expiry after 16 run cycles
        submit(32'd100, 32'd75, acc);
        wait_calc_start();
        run = 1;
        while (!resp_valid && run < 40) begin tick(); run++; end
        chk("timeout_run_cycles", 32'(run - 1), 32'd16);
        chk("timeout_flag", 32'(resp_timeout), 32'd1);
        chk("timeout_result", resp_result, 32'd0);
        handshake();

        // Result write on the last watchdog cycle wins
        submit(32'd9, 32'd6, acc);
        wait_calc_start();
        repeat (15) tick();
        core_write(5'd10, 32'd3);
        chk("race_resp_valid", 32'(resp_valid), 32'd1);
        chk("race_timeout", 32'(resp_timeout), 32'd0);
        chk("race_result", resp_result, 32'd3);
        handshake();

        // Filtering of other registers and of writes outside RUN, plus backpressure
        submit(32'd21, 32'd14, acc);
        wait_calc_start();
        core_write(5'd5, 32'd111);
        core_write(5'd28, 32'd222);
        core_write(5'd31, 32'd1);
        chk("filter_still_running", 32'(calc_start), 32'd1);
        tick();
        core_write(5'd10, 32'd7);
        chk("filter_result", resp_result, 32'd7);
        core_write(5'd10, 32'd99);
        req_valid = 1'b1; req_a = 32'd5; req_b = 32'd0;
        repeat (7) begin
            chk("bp_result_stable", resp_result, 32'd7);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        handshake();
        chk("bp_no_bypass", 32'(resp_valid), 32'd0);

        // Back-to-back jobs
        run_job(32'd12, 32'd8, 3, 32'd4);
        run_job(32'd17, 32'd5, 2, 32'd1);

        // Async reset in the middle of RUN discards the job
        submit(32'd30, 32'd20, acc);
        wait_calc_start();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_req_ready",  32'(req_ready),  32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_calc_start", 32'(calc_start), 32'd0);
        chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrst_gcd_a",      gcd_a,           32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("midrst_no_resp", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
